// File: rtl/dac_spi_tx_pkg.sv
// Shared types and default frame constants for the serial DAC transmitter
// (TLC5615-class target: 12-bit frame, 8-bit sample, no leading zeros).
package dac_spi_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } dac_state_e;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_FRAME_W = 12;
    localparam int DEF_LEAD_W  = 0;
    localparam int DEF_CLK_DIV = 2;
    localparam int DEF_CS_GAP  = 2;

    // Bits needed to hold 0..count-1, never narrower than one bit.
    function automatic int cnt_w(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/dac_spi_tx.sv
// Serialises one sample per frame to a 3-wire serial DAC (CS_N, SCLK, DIN),
// MSB first, DIN launched on SCLK falling edges and sampled by the DAC on rising.
module dac_spi_tx
    import dac_spi_tx_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int LEAD_W  = DEF_LEAD_W,
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int CS_GAP  = DEF_CS_GAP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              ready,
    output logic              dac_cs_n,
    output logic              dac_sclk,
    output logic              dac_din,
    output logic              frame_done
);

    localparam int TAIL_W = FRAME_W - LEAD_W - DATA_W;
    localparam int DIV_W  = cnt_w(CLK_DIV);
    localparam int BIT_W  = cnt_w(FRAME_W);
    localparam int GAP_W  = cnt_w(CS_GAP);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    dac_state_e         state_reg, state_next;
    logic [FRAME_W-1:0] shift_reg, shift_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic [BIT_W-1:0]   bit_reg, bit_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;
    logic               cs_n_reg, cs_n_next;
    logic               sclk_reg, sclk_next;
    logic               din_reg, din_next;
    logic               done_reg, done_next;

    logic [FRAME_W-1:0] frame_word;
    logic [FRAME_W-1:0] shifted;

    // Zero-extending then shifting left by the tail width leaves LEAD_W zeros on top.
    assign frame_word = FRAME_W'(sample_in) << TAIL_W;
    assign shifted    = shift_reg << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            shift_reg <= '0;
            div_reg   <= '0;
            bit_reg   <= '0;
            gap_reg   <= '0;
            cs_n_reg  <= 1'b1;
            sclk_reg  <= 1'b0;
            din_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            div_reg   <= div_next;
            bit_reg   <= bit_next;
            gap_reg   <= gap_next;
            cs_n_reg  <= cs_n_next;
            sclk_reg  <= sclk_next;
            din_reg   <= din_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        div_next   = div_reg;
        bit_next   = bit_reg;
        gap_next   = gap_reg;
        cs_n_next  = cs_n_reg;
        sclk_next  = sclk_reg;
        din_next   = din_reg;
        done_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (sample_valid) begin
                    shift_next = frame_word;
                    cs_n_next  = 1'b0;
                    sclk_next  = 1'b0;
                    din_next   = frame_word[FRAME_W-1];
                    div_next   = '0;
                    bit_next   = '0;
                    state_next = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (div_reg == DIV_LAST) begin
                    div_next  = '0;
                    sclk_next = ~sclk_reg;
                    // Only the falling toggle moves data; the rising one is the DAC's sample point.
                    if (sclk_reg) begin
                        if (bit_reg == BIT_LAST) begin
                            cs_n_next  = 1'b1;
                            din_next   = 1'b0;
                            done_next  = 1'b1;
                            gap_next   = '0;
                            state_next = ST_GAP;
                        end else begin
                            bit_next   = bit_reg + 1'b1;
                            shift_next = shifted;
                            din_next   = shifted[FRAME_W-1];
                        end
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end

            ST_GAP: begin
                if (gap_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    assign ready      = (state_reg == ST_IDLE);
    assign dac_cs_n   = cs_n_reg;
    assign dac_sclk   = sclk_reg;
    assign dac_din    = din_reg;
    assign frame_done = done_reg;

endmodule
